exc_commit_ctrl: RTL and testbench

- Commit-point trap sequencer at the WB stage.
- Arbitrates between three events in the same cycle: the pending interrupt request from the interrupt controller, a synchronous exception carried by the WB instruction, and an ERTN at WB.
- For the winning event it sequences the pipeline flush, the PC redirect and the CSR side-effects (ERA/ESTAT.Ecode/BADV write, CRMD save/restore).
- Owns the in_exception flag and the ertn pulse consumed by the interrupt controller.

---
 rtl/exc_commit_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_exc_commit_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_commit_ctrl.sv
// Commit-point trap sequencer: arbitrates interrupt / exception / ERTN at WB and sequences flush, redirect and CSR writes.
// Optional event counters are enabled with the EXC_COMMIT_STAT_EN macro.
module exc_commit_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 32'd2,
  parameter logic [5:0]  ECODE_INT    = 6'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        wb_excp,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic        wb_badv_valid,
  input  logic [31:0] wb_badv,
  input  logic        wb_ertn,
  input  logic        int_req,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        csr_ex_we,
  output logic [31:0] csr_era_wdata,
  output logic [5:0]  csr_ecode,
  output logic [8:0]  csr_esubcode,
  output logic        csr_badv_we,
  output logic [31:0] csr_badv,
  output logic        csr_ertn_we,
  output logic        ertn,
  output logic        in_exception
`ifdef EXC_COMMIT_STAT_EN
  ,
  output logic [31:0] stat_int_cnt,
  output logic [31:0] stat_exc_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_INT  = 2'd1,
    EV_EXC  = 2'd2,
    EV_ERTN = 2'd3
  } evt_e;

  // DRAIN covers the FLUSH_CYCLES-1 cycles after COMMIT; the counter holds the cycles left after the current one.
  localparam logic       HAS_DRAIN  = (FLUSH_CYCLES > 32'd1);
  localparam logic [3:0] DRAIN_LOAD = HAS_DRAIN ? 4'(FLUSH_CYCLES - 32'd2) : 4'd0;

  state_e      state_r;
  state_e      state_s;
  logic [3:0]  drain_cnt_r;
  logic [3:0]  drain_cnt_s;
  evt_e        evt_s;

  logic        flush_s;
  logic        redirect_valid_s;
  logic [31:0] redirect_pc_s;
  logic        csr_ex_we_s;
  logic [31:0] csr_era_wdata_s;
  logic [5:0]  csr_ecode_s;
  logic [8:0]  csr_esubcode_s;
  logic        csr_badv_we_s;
  logic [31:0] csr_badv_s;
  logic        csr_ertn_we_s;
  logic        ertn_s;
  logic        in_exception_s;

  // Event arbitration: only an idle sequencer with a valid WB instruction samples events.
  always_comb begin
    evt_s = EV_NONE;
    if ((state_r == ST_IDLE) && wb_valid) begin
      if (int_req) begin
        evt_s = EV_INT;
      end else if (wb_excp) begin
        evt_s = EV_EXC;
      end else if (wb_ertn) begin
        evt_s = EV_ERTN;
      end else begin
        evt_s = EV_NONE;
      end
    end else begin
      evt_s = EV_NONE;
    end
  end

  // State and drain counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      drain_cnt_r <= 4'd0;
    end else begin
      state_r     <= state_s;
      drain_cnt_r <= drain_cnt_s;
    end
  end

  // Next-state logic; the drain counter only counts down and stops at zero.
  always_comb begin
    state_s     = state_r;
    drain_cnt_s = drain_cnt_r;
    case (state_r)
      ST_IDLE: begin
        drain_cnt_s = 4'd0;
        if (evt_s != EV_NONE) begin
          state_s = ST_COMMIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        if (HAS_DRAIN) begin
          state_s     = ST_DRAIN;
          drain_cnt_s = DRAIN_LOAD;
        end else begin
          state_s     = ST_IDLE;
          drain_cnt_s = 4'd0;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r == 4'd0) begin
          state_s     = ST_IDLE;
          drain_cnt_s = 4'd0;
        end else begin
          state_s     = ST_DRAIN;
          drain_cnt_s = drain_cnt_r - 4'd1;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        drain_cnt_s = 4'd0;
      end
    endcase
  end

  // Output next values: operands are taken on the sampling edge so later CSR changes cannot leak in.
  always_comb begin
    flush_s          = (state_s != ST_IDLE);
    redirect_valid_s = 1'b0;
    redirect_pc_s    = 32'd0;
    csr_ex_we_s      = 1'b0;
    csr_era_wdata_s  = 32'd0;
    csr_ecode_s      = 6'd0;
    csr_esubcode_s   = 9'd0;
    csr_badv_we_s    = 1'b0;
    csr_badv_s       = 32'd0;
    csr_ertn_we_s    = 1'b0;
    ertn_s           = 1'b0;
    in_exception_s   = in_exception;
    case (evt_s)
      EV_INT: begin
        redirect_valid_s = 1'b1;
        redirect_pc_s    = csr_eentry;
        csr_ex_we_s      = 1'b1;
        csr_era_wdata_s  = wb_pc;
        csr_ecode_s      = ECODE_INT;
        csr_esubcode_s   = 9'd0;
        in_exception_s   = 1'b1;
      end
      EV_EXC: begin
        redirect_valid_s = 1'b1;
        redirect_pc_s    = csr_eentry;
        csr_ex_we_s      = 1'b1;
        csr_era_wdata_s  = wb_pc;
        csr_ecode_s      = wb_ecode;
        csr_esubcode_s   = wb_esubcode;
        csr_badv_we_s    = wb_badv_valid;
        csr_badv_s       = wb_badv;
        in_exception_s   = 1'b1;
      end
      EV_ERTN: begin
        redirect_valid_s = 1'b1;
        redirect_pc_s    = csr_era;
        csr_ertn_we_s    = 1'b1;
        ertn_s           = 1'b1;
        in_exception_s   = 1'b0;
      end
      EV_NONE: begin
        in_exception_s = in_exception;
      end
      default: begin
        in_exception_s = in_exception;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      csr_ex_we      <= 1'b0;
      csr_era_wdata  <= 32'd0;
      csr_ecode      <= 6'd0;
      csr_esubcode   <= 9'd0;
      csr_badv_we    <= 1'b0;
      csr_badv       <= 32'd0;
      csr_ertn_we    <= 1'b0;
      ertn           <= 1'b0;
      in_exception   <= 1'b0;
    end else begin
      flush          <= flush_s;
      redirect_valid <= redirect_valid_s;
      redirect_pc    <= redirect_pc_s;
      csr_ex_we      <= csr_ex_we_s;
      csr_era_wdata  <= csr_era_wdata_s;
      csr_ecode      <= csr_ecode_s;
      csr_esubcode   <= csr_esubcode_s;
      csr_badv_we    <= csr_badv_we_s;
      csr_badv       <= csr_badv_s;
      csr_ertn_we    <= csr_ertn_we_s;
      ertn           <= ertn_s;
      in_exception   <= in_exception_s;
    end
  end

`ifdef EXC_COMMIT_STAT_EN
  evt_e evt_r;

  // Remember which event is committing so the counters step in the COMMIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_r <= EV_NONE;
    end else begin
      evt_r <= evt_s;
    end
  end

  // Free-running wrap-around event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_int_cnt <= 32'd0;
      stat_exc_cnt <= 32'd0;
    end else if (state_r == ST_COMMIT) begin
      if (evt_r == EV_INT) begin
        stat_int_cnt <= stat_int_cnt + 32'd1;
      end else if (evt_r == EV_EXC) begin
        stat_exc_cnt <= stat_exc_cnt + 32'd1;
      end else begin
        stat_int_cnt <= stat_int_cnt;
      end
    end else begin
      stat_int_cnt <= stat_int_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Bench for exc_commit_ctrl: three instances (FLUSH_CYCLES 2, 1, 4) share stimulus and are compared
// every cycle with a countdown-based reference model.
module tb_exc_commit_ctrl;

  localparam logic [5:0] ECODE_INT = 6'd0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid, wb_excp, wb_badv_valid, wb_ertn, int_req;
  logic [31:0] wb_pc, wb_badv, csr_eentry, csr_era;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;

  logic        flush_o [3];
  logic        redirect_valid_o [3];
  logic [31:0] redirect_pc_o [3];
  logic        csr_ex_we_o [3];
  logic [31:0] csr_era_wdata_o [3];
  logic [5:0]  csr_ecode_o [3];
  logic [8:0]  csr_esubcode_o [3];
  logic        csr_badv_we_o [3];
  logic [31:0] csr_badv_o [3];
  logic        csr_ertn_we_o [3];
  logic        ertn_o [3];
  logic        in_exception_o [3];
`ifdef EXC_COMMIT_STAT_EN
  logic [31:0] stat_int_o [3];
  logic [31:0] stat_exc_o [3];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    exc_commit_ctrl #(
      .FLUSH_CYCLES((g == 0) ? 2 : ((g == 1) ? 1 : 4)),
      .ECODE_INT   (ECODE_INT)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wb_valid      (wb_valid),
      .wb_pc         (wb_pc),
      .wb_excp       (wb_excp),
      .wb_ecode      (wb_ecode),
      .wb_esubcode   (wb_esubcode),
      .wb_badv_valid (wb_badv_valid),
      .wb_badv       (wb_badv),
      .wb_ertn       (wb_ertn),
      .int_req       (int_req),
      .csr_eentry    (csr_eentry),
      .csr_era       (csr_era),
      .flush         (flush_o[g]),
      .redirect_valid(redirect_valid_o[g]),
      .redirect_pc   (redirect_pc_o[g]),
      .csr_ex_we     (csr_ex_we_o[g]),
      .csr_era_wdata (csr_era_wdata_o[g]),
      .csr_ecode     (csr_ecode_o[g]),
      .csr_esubcode  (csr_esubcode_o[g]),
      .csr_badv_we   (csr_badv_we_o[g]),
      .csr_badv      (csr_badv_o[g]),
      .csr_ertn_we   (csr_ertn_we_o[g]),
      .ertn          (ertn_o[g]),
      .in_exception  (in_exception_o[g])
`ifdef EXC_COMMIT_STAT_EN
      ,
      .stat_int_cnt  (stat_int_o[g]),
      .stat_exc_cnt  (stat_exc_o[g])
`endif
    );
  end

  int checks = 0;
  int errors = 0;

  // Reference model: remaining flush cycles per instance plus expected strobes for the current cycle.
  int          rem [3];
  logic        m_inexc [3];
  logic        e_flush [3], e_rv [3], e_exwe [3], e_bwe [3], e_ertnwe [3], e_ertn [3];
  logic [31:0] e_rpc [3], e_era [3], e_badv [3];
  logic [5:0]  e_ecode [3];
  logic [8:0]  e_sub [3];
  int          n_int = 0;
  int          n_exc = 0;

  function automatic int len_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  task automatic chk1(input string tag, input int k, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      rem[k] = 0; m_inexc[k] = 1'b0; e_flush[k] = 1'b0; e_rv[k] = 1'b0;
      e_exwe[k] = 1'b0; e_bwe[k] = 1'b0; e_ertnwe[k] = 1'b0; e_ertn[k] = 1'b0;
    end
  endtask

  // One clock edge of the model: a new event is accepted only when the instance is not flushing.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int k = 0; k < 3; k++) begin
        e_rv[k] = 1'b0; e_exwe[k] = 1'b0; e_bwe[k] = 1'b0; e_ertnwe[k] = 1'b0; e_ertn[k] = 1'b0;
        if (rem[k] == 0 && wb_valid && (int_req || wb_excp || wb_ertn)) begin
          rem[k] = len_of(k);
          e_flush[k] = 1'b1;
          e_rv[k] = 1'b1;
          if (int_req) begin
            e_exwe[k] = 1'b1; e_era[k] = wb_pc; e_ecode[k] = ECODE_INT; e_sub[k] = 9'd0;
            e_rpc[k] = csr_eentry; m_inexc[k] = 1'b1;
            if (k == 0) n_int++;
          end else if (wb_excp) begin
            e_exwe[k] = 1'b1; e_era[k] = wb_pc; e_ecode[k] = wb_ecode; e_sub[k] = wb_esubcode;
            e_bwe[k] = wb_badv_valid; e_badv[k] = wb_badv;
            e_rpc[k] = csr_eentry; m_inexc[k] = 1'b1;
            if (k == 0) n_exc++;
          end else begin
            e_ertnwe[k] = 1'b1; e_ertn[k] = 1'b1; e_rpc[k] = csr_era; m_inexc[k] = 1'b0;
          end
        end else begin
          if (rem[k] > 0) rem[k]--;
          e_flush[k] = (rem[k] > 0);
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk1("flush", k, flush_o[k], e_flush[k]);
      chk1("redirect_valid", k, redirect_valid_o[k], e_rv[k]);
      chk1("csr_ex_we", k, csr_ex_we_o[k], e_exwe[k]);
      chk1("csr_badv_we", k, csr_badv_we_o[k], e_bwe[k]);
      chk1("csr_ertn_we", k, csr_ertn_we_o[k], e_ertnwe[k]);
      chk1("ertn", k, ertn_o[k], e_ertn[k]);
      chk1("in_exception", k, in_exception_o[k], m_inexc[k]);
      if (e_rv[k]) chkv("redirect_pc", k, redirect_pc_o[k], e_rpc[k]);
      if (e_exwe[k]) begin
        chkv("csr_era_wdata", k, csr_era_wdata_o[k], e_era[k]);
        chkv("csr_ecode", k, 32'(csr_ecode_o[k]), 32'(e_ecode[k]));
        chkv("csr_esubcode", k, 32'(csr_esubcode_o[k]), 32'(e_sub[k]));
      end
      if (e_bwe[k]) chkv("csr_badv", k, csr_badv_o[k], e_badv[k]);
    end
  endtask

  task automatic check_zero();
    for (int k = 0; k < 3; k++) begin
      chk1("rst_flush", k, flush_o[k], 1'b0);
      chk1("rst_redirect_valid", k, redirect_valid_o[k], 1'b0);
      chkv("rst_redirect_pc", k, redirect_pc_o[k], 32'd0);
      chk1("rst_csr_ex_we", k, csr_ex_we_o[k], 1'b0);
      chkv("rst_csr_era_wdata", k, csr_era_wdata_o[k], 32'd0);
      chkv("rst_csr_ecode", k, 32'(csr_ecode_o[k]), 32'd0);
      chkv("rst_csr_esubcode", k, 32'(csr_esubcode_o[k]), 32'd0);
      chk1("rst_csr_badv_we", k, csr_badv_we_o[k], 1'b0);
      chkv("rst_csr_badv", k, csr_badv_o[k], 32'd0);
      chk1("rst_csr_ertn_we", k, csr_ertn_we_o[k], 1'b0);
      chk1("rst_ertn", k, ertn_o[k], 1'b0);
      chk1("rst_in_exception", k, in_exception_o[k], 1'b0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    wb_valid = 1'b0; wb_excp = 1'b0; wb_ertn = 1'b0; int_req = 1'b0; wb_badv_valid = 1'b0;
  endtask

  task automatic set_exc(input logic [31:0] pc, input logic [5:0] ec, input logic [8:0] sub,
                         input logic bv, input logic [31:0] badv);
    wb_valid = 1'b1; wb_excp = 1'b1; wb_pc = pc; wb_ecode = ec; wb_esubcode = sub;
    wb_badv_valid = bv; wb_badv = badv;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    wb_pc = 32'd0; wb_badv = 32'd0; wb_ecode = 6'd0; wb_esubcode = 9'd0;
    csr_eentry = 32'h1C00_8000; csr_era = 32'd0;
    model_reset();
    #2;
    check_zero();
    step();
    step();
    rst_n = 1'b1;
    step();

    // Synchronous exception, then quiet cycles covering the flush tail.
    set_exc(32'h1C00_0100, 6'h0B, 9'h005, 1'b0, 32'h0);
    step();
    idle_inputs();
    for (int i = 0; i < 6; i++) step();

    // Interrupt and exception together: interrupt wins.
    set_exc(32'h1C00_0200, 6'h0C, 9'h1FF, 1'b1, 32'h1234_5678);
    int_req = 1'b1;
    step();
    idle_inputs();
    for (int i = 0; i < 6; i++) step();

    // ERTN while in the handler.
    wb_valid = 1'b1; wb_ertn = 1'b1; csr_era = 32'h1C00_0204;
    step();
    idle_inputs();
    csr_era = 32'h0BAD_0BAD;
    for (int i = 0; i < 6; i++) step();

    // Exception with BADV; a second exception arrives in the DRAIN cycle; eentry changes mid-flight.
    set_exc(32'h1C00_0300, 6'h08, 9'h001, 1'b1, 32'hDEAD_0000);
    step();
    idle_inputs();
    csr_eentry = 32'h1C00_9000;
    step();
    set_exc(32'h1C00_0304, 6'h09, 9'h002, 1'b0, 32'h0);
    step();
    idle_inputs();
    for (int i = 0; i < 6; i++) step();

    // Reset asserted in the COMMIT cycle.
    wb_valid = 1'b1; int_req = 1'b1; wb_pc = 32'h1C00_0400;
    step();
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_zero();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();

    // Back-to-back events held continuously.
    set_exc(32'h1C00_0500, 6'h01, 9'h003, 1'b0, 32'h0);
    for (int i = 0; i < 12; i++) step();
    idle_inputs();
    wb_valid = 1'b1; wb_ertn = 1'b1; csr_era = 32'h1C00_0600;
    for (int i = 0; i < 8; i++) step();
    idle_inputs();

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      wb_valid      = ($urandom_range(0, 3) != 0);
      int_req       = ($urandom_range(0, 5) == 0);
      wb_excp       = ($urandom_range(0, 3) == 0);
      wb_ertn       = ($urandom_range(0, 3) == 0);
      wb_badv_valid = $urandom_range(0, 1) == 1;
      wb_pc         = $urandom;
      wb_badv       = $urandom;
      wb_ecode      = 6'($urandom);
      wb_esubcode   = 9'($urandom);
      csr_eentry    = $urandom;
      csr_era       = $urandom;
      step();
    end
    idle_inputs();
    for (int i = 0; i < 6; i++) step();

`ifdef EXC_COMMIT_STAT_EN
    chkv("stat_int_cnt", 0, stat_int_o[0], 32'(n_int));
    chkv("stat_exc_cnt", 0, stat_exc_o[0], 32'(n_exc));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
